// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with a 2-flop synchroniser, a 3-sample majority vote,
// framing-error detection and break recovery.
module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 868,
   localparam int CNT_W = $clog2(CLKS_PER_BIT)
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       RxD,
   output logic [7:0] RxD_data,
   output logic       RxD_data_in_ready,
   output logic       RxD_frame_err,
   output logic       RxD_busy
);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] MID  = CNT_W'(CLKS_PER_BIT / 2);
   state_t           state, state_n;
   logic             s1, rx_s;
   logic [2:0]       v;
   logic [CNT_W-1:0] timer, timer_n;
   logic [2:0]       idx, idx_n;
   logic [7:0]       shift, shift_n, data_n;
   logic             ready_n, ferr_n, busy_n, vote, wrap;
   assign vote = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   assign wrap = timer == LAST;
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1                <= 1'b1;
         rx_s              <= 1'b1;
         v                 <= 3'b111;
         state             <= IDLE;
         timer             <= '0;
         idx               <= '0;
         shift             <= '0;
         RxD_data          <= '0;
         RxD_data_in_ready <= 1'b0;
         RxD_frame_err     <= 1'b0;
         RxD_busy          <= 1'b0;
      end else begin
         s1                <= RxD;
         rx_s              <= s1;
         v                 <= {v[1:0], rx_s};
         state             <= state_n;
         timer             <= timer_n;
         idx               <= idx_n;
         shift             <= shift_n;
         RxD_data          <= data_n;
         RxD_data_in_ready <= ready_n;
         RxD_frame_err     <= ferr_n;
         RxD_busy          <= busy_n;
      end
   end
   // v[0] is the previous rx_s, so v[0] & ~rx_s marks the start edge
   always_comb begin
      state_n = state;
      timer_n = wrap ? '0 : timer + 1'b1;
      idx_n   = idx;
      shift_n = shift;
      data_n  = RxD_data;
      ready_n = 1'b0;
      ferr_n  = 1'b0;
      busy_n  = RxD_busy;
      case (state)
         IDLE: begin
            timer_n = '0;
            if (v[0] && !rx_s) begin
               busy_n  = 1'b1;
               state_n = START;
            end
         end
         START: if (timer == MID) begin
            timer_n = '0;
            idx_n   = '0;
            busy_n  = !vote;
            state_n = vote ? IDLE : DATA;
         end
         DATA: if (wrap) begin
            shift_n = {vote, shift[7:1]};
            idx_n   = idx + 3'd1;
            if (idx == 3'd7) state_n = STOP;
         end
         // leaves at the stop-bit midpoint so a zero-gap next start edge is caught
         STOP: if (wrap) begin
            if (vote) begin
               data_n  = shift;
               ready_n = 1'b1;
               busy_n  = 1'b0;
               state_n = IDLE;
            end else begin
               ferr_n  = 1'b1;
               timer_n = '0;
               state_n = BREAK;
            end
         end
         BREAK: begin
            if (!rx_s) timer_n = '0;
            else if (wrap) begin
               busy_n  = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule
